// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: the four SPI wires, mode pins and the parallel tx/rx side.
// The slave modport is the endpoint view; the master modport is the driving side.
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic              SPI_CLK;
  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              underrun;

  modport slave (
    input  SPI_CLK, CS, MOSI, cpol, cpha, tx_data, tx_valid,
    output MISO, tx_ready, rx_data, rx_valid, busy, underrun
  );

  modport master (
    output SPI_CLK, CS, MOSI, cpol, cpha, tx_data, tx_valid,
    input  MISO, tx_ready, rx_data, rx_valid, busy, underrun
  );
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI slave, LSB first, all four CPOL/CPHA modes, single-word tx buffer.
// Build option SPI_SLAVE_MISO_TRISTATE_EN: MISO floats (1'bz) whenever no frame is in progress.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  spi_slave_if.slave  spi
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sclk_q, cs_q;
  logic [1:0]        mosi_q;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_full_q, buf_full_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  // Edges come from comparing the synchroniser output [1] with the extra flop [2].
  logic sclk_rise, sclk_fall, cs_low, cs_fall;
  logic lead_e, trail_e, sample_e, shift_e, hs, busy;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_low    = ~cs_q[1];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign lead_e    = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_e   = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_e  = mode_q[0] ? trail_e : lead_e;
  assign shift_e   = mode_q[0] ? lead_e : trail_e;
  assign hs        = spi.tx_valid & ~buf_full_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    rx_valid_d = 1'b0;
    underrun_d = underrun_q;
    first_d    = first_q;
    rx_data_d  = rx_data_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;

    if (hs) begin
      buf_d      = spi.tx_data;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          mode_d  = {spi.cpol, spi.cpha};
          first_d = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!cs_low) begin
          state_d = IDLE;
        end else begin
          // A capture landing in this cycle is not visible here; it waits for the next LOAD.
          tx_sh_d = buf_full_q ? buf_q : '0;
          if (buf_full_q) buf_full_d = 1'b0;
          // Only the word that opens a frame counts as an underrun; the trailing
          // LOAD after the last word of a frame is normally empty.
          if (!buf_full_q && first_q) underrun_d = 1'b1;
          first_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!cs_low) begin
          state_d = IDLE;
        end else begin
          if (sample_e) begin
            rx_sh_d = {mosi_q[1], rx_sh_q[DATA_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              rx_data_d  = {mosi_q[1], rx_sh_q[DATA_W-1:1]};
              rx_valid_d = 1'b1;
              state_d    = LOAD;
            end
          end
          // No shift before the first sample of a word: covers the cpha=1 first
          // leading edge and the cpha=0 trailing edge that follows the last bit.
          if (shift_e && (cnt_q != '0)) tx_sh_d = {1'b0, tx_sh_q[DATA_W-1:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sclk_q     <= '0;
      cs_q       <= '1;
      mosi_q     <= '0;
      mode_q     <= '0;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      first_q    <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= {sclk_q[1:0], spi.SPI_CLK};
      cs_q       <= {cs_q[1:0], spi.CS};
      mosi_q     <= {mosi_q[0], spi.MOSI};
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      first_q    <= first_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    rx_sh_q <= rx_sh_d;
    tx_sh_q <= tx_sh_d;
    buf_q   <= buf_d;
  end

  assign spi.tx_ready = ~buf_full_q;
  assign spi.rx_data  = rx_data_q;
  assign spi.rx_valid = rx_valid_q;
  assign spi.busy     = busy;
  assign spi.underrun = underrun_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign spi.MISO = busy ? tx_sh_q[0] : 1'bz;
`else
  assign spi.MISO = busy & tx_sh_q[0];
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: a bit-banged SPI master plus a word-level model
// of what each side should receive.
module tb_spi_slave;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) bus ();
  spi_slave #(.DATA_W(8)) dut (.clk_i(clk), .rst_ni(rst_n), .spi(bus));

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] mosi_bits;
  logic [23:0] miso_got;
  logic [7:0]  tx_words [3];
  logic [7:0]  rx_words [3];
  logic [7:0]  rx_got [$];
  logic        exp_underrun;
  logic [7:0]  last_rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && bus.rx_valid === 1'b1) rx_got.push_back(bus.rx_data);

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic push_tx(input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    while (bus.tx_ready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      chk("tx_ready_timeout", bus.tx_ready, 1);
    end else begin
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk("tx_ready_drop", bus.tx_ready, 0);
    end
  endtask

  task automatic refill(input int nw);
    for (int w = 1; w < nw; w++) push_tx(tx_words[w]);
  endtask

  task automatic spi_xfer(input logic [1:0] mode, input int nbits, input bit mid_mode, input bit keep_cs);
    logic cpol_m, cpha_m;
    cpol_m = mode[1];
    cpha_m = mode[0];
    @(negedge clk);
    bus.cpol    = cpol_m;
    bus.cpha    = cpha_m;
    bus.SPI_CLK = cpol_m;
    bus.MOSI    = mosi_bits[0];
    repeat (4) @(negedge clk);
    bus.CS = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_lat2", bus.busy, 0);
    @(negedge clk);
    chk("busy_lat3", bus.busy, 1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (mid_mode && k == 3) begin
        bus.cpol = ~cpol_m;
        bus.cpha = ~cpha_m;
      end
      if (!cpha_m) begin
        bus.MOSI = mosi_bits[k];
        repeat (H) @(negedge clk);
        bus.SPI_CLK = ~bus.SPI_CLK;
        miso_got[k] = bus.MISO;
        repeat (H) @(negedge clk);
        bus.SPI_CLK = ~bus.SPI_CLK;
      end else begin
        bus.SPI_CLK = ~bus.SPI_CLK;
        bus.MOSI = mosi_bits[k];
        repeat (H) @(negedge clk);
        bus.SPI_CLK = ~bus.SPI_CLK;
        miso_got[k] = bus.MISO;
        repeat (H) @(negedge clk);
      end
    end
    repeat (2 * H) @(negedge clk);
    if (!keep_cs) begin
      bus.CS = 1'b1;
      repeat (3) @(negedge clk);
      chk("busy_drop", bus.busy, 0);
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [1:0] mode, input int nw, input bit mid, input bit preload);
    logic [7:0] exp_w;
    for (int w = 0; w < nw; w++) mosi_bits[w*8 +: 8] = rx_words[w];
    rx_got.delete();
    if (preload) push_tx(tx_words[0]);
    fork
      spi_xfer(mode, nw * 8, mid, 1'b0);
      begin
        if (preload) refill(nw);
      end
    join
    if (!preload) exp_underrun = 1'b1;
    last_rx = rx_words[nw-1];
    chk("rx_count", rx_got.size(), nw);
    for (int w = 0; w < nw; w++) begin
      exp_w = preload ? tx_words[w] : 8'h00;
      chk("miso_word", miso_got[w*8 +: 8], exp_w);
      chk("rx_word", (w < rx_got.size()) ? rx_got[w] : 8'hxx, rx_words[w]);
    end
    chk("rx_data", bus.rx_data, last_rx);
    chk("underrun", bus.underrun, exp_underrun);
    chk("tx_ready_idle", bus.tx_ready, 1);
  endtask

  initial begin
    logic [1:0] m;
    int nw;
    rst_n        = 1'b0;
    bus.SPI_CLK  = 1'b0;
    bus.CS       = 1'b1;
    bus.MOSI     = 1'b0;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    exp_underrun = 1'b0;
    last_rx      = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_underrun", bus.underrun, 0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    chk("rst_miso", bus.MISO, 1'bz);
`else
    chk("rst_miso", bus.MISO, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 directed word exchange.
    tx_words[0] = 8'hA5; rx_words[0] = 8'h3C;
    run_frame(2'd0, 1, 1'b0, 1'b1);

    // Modes 1..3 with the mode pins flipped mid-frame.
    for (int i = 1; i < 4; i++) begin
      tx_words[0] = 8'h96; rx_words[0] = 8'h69;
      m = 2'(i);
      run_frame(m, 1, 1'b1, 1'b1);
    end

    // Three back-to-back words under one CS.
    tx_words[0] = 8'h01; tx_words[1] = 8'h02; tx_words[2] = 8'h03;
    rx_words[0] = 8'hF0; rx_words[1] = 8'h0F; rx_words[2] = 8'hFF;
    run_frame(2'd0, 3, 1'b0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      m  = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 3);
      for (int w = 0; w < 3; w++) begin
        tx_words[w] = 8'($urandom);
        rx_words[w] = 8'($urandom);
      end
      run_frame(m, nw, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Frame aborted after 5 bits.
    tx_words[0] = 8'($urandom); rx_words[0] = 8'($urandom);
    mosi_bits[7:0] = rx_words[0];
    m = 2'($urandom_range(0, 3));
    push_tx(tx_words[0]);
    rx_got.delete();
    spi_xfer(m, 5, 1'b0, 1'b0);
    chk("abort_rx_count", rx_got.size(), 0);
    chk("abort_rx_data", bus.rx_data, last_rx);
    chk("abort_miso_bits", miso_got[4:0], tx_words[0][4:0]);
    chk("abort_tx_ready", bus.tx_ready, 1);
    tx_words[0] = 8'($urandom); rx_words[0] = 8'($urandom);
    run_frame(m, 1, 1'b0, 1'b1);

    // Empty tx buffer at frame start, then underrun stays sticky.
    rx_words[0] = 8'($urandom);
    run_frame(2'($urandom_range(0, 3)), 1, 1'b0, 1'b0);
    tx_words[0] = 8'($urandom); rx_words[0] = 8'($urandom);
    run_frame(2'($urandom_range(0, 3)), 1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame.
    tx_words[0] = 8'($urandom); rx_words[0] = 8'($urandom);
    mosi_bits[7:0] = rx_words[0];
    push_tx(tx_words[0]);
    spi_xfer(2'($urandom_range(0, 3)), 4, 1'b0, 1'b1);
    push_tx(8'($urandom));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_tx_ready", bus.tx_ready, 1);
    chk("mrst_rx_valid", bus.rx_valid, 0);
    chk("mrst_rx_data", bus.rx_data, 0);
    chk("mrst_underrun", bus.underrun, 0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    chk("mrst_miso", bus.MISO, 1'bz);
`else
    chk("mrst_miso", bus.MISO, 0);
`endif
    @(negedge clk);
    bus.CS = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_underrun = 1'b0;
    last_rx = 8'h00;
    repeat (2) @(negedge clk);
    tx_words[0] = 8'($urandom); rx_words[0] = 8'($urandom);
    run_frame(2'($urandom_range(0, 3)), 1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave endpoint that pairs with the team's SPI master on the same four-wire bus. It oversamples SPI_CLK, CS and MOSI in the local `clk` domain and drives MISO. It deserialises received words to a parallel output with a one-cycle valid strobe, and serialises transmit words supplied through a valid/ready handshake. It supports all four CPOL/CPHA modes and shifts LSB first, matching the master's right-shift register.

## Interface
- Data_Width, 8, word length in bits (≥2)
- clk  input  1  system clock; must be ≥8× SPI_CLK frequency
- rst  input  1  asynchronous reset, active-low
- SPI_CLK  input  1  serial clock from master (asynchronous to clk)
- CS  input  1  chip select, active-low
- MOSI  input  1  serial data from master
- MISO  output  1  serial data to master
- cpol, cpha  input  1 each  SPI mode; sampled only while CS is high
- tx_data  input  Data_Width  next word to transmit
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  transmit buffer empty; transfer on tx_valid&tx_ready
- rx_data  output  Data_Width  last complete received word
- rx_valid  output  1  one-cycle strobe, rx_data updated
- busy  output  1  CS is synchronised low (frame in progress)
- underrun  output  1  sticky; a frame started with an empty tx buffer

## Operation
- SPI_CLK, CS and MOSI each pass through a 2-flop synchroniser. Edge detection compares the sync output with a 3rd flop.
- Leading edge is rising when cpol=0 and falling when cpol=1.
- cpha=0: sample MOSI on leading edges, shift MISO on trailing edges.
- cpha=1: shift on leading edges, sample on trailing edges.
- cpol/cpha are latched into a mode register at the synchronised CS falling edge. Changes while busy have no effect.
- States:
  - IDLE: CS high. On the synchronised CS fall, go to LOAD.
  - LOAD: one cycle. The shift register takes the tx buffer; the buffer is emptied. If the buffer is empty, the register loads all-zero and underrun is set. Bit counter = 0. Go to SHIFT.
  - SHIFT:
    - Each sample edge shifts MOSI into the rx register MSB and increments the bit counter.
    - Each shift edge moves the tx register right, so MISO = tx register bit 0.
    - When the counter reaches Data_Width, rx_data is loaded, rx_valid pulses, and the state goes to LOAD. This allows back-to-back words while CS stays low.
    - cpha=1: the first leading edge of each word does not shift. The bit already on MISO is driven.
- MISO presents tx register bit 0 combinationally from LOAD onward. The cpha=0 first bit is therefore valid before the first leading edge.
- CS rising in any state: return to IDLE the next cycle. The partial word is discarded, no rx_valid is issued, and the consumed tx word is lost. The tx buffer is unaffected.
- tx buffer is a single register. tx_ready = buffer empty.
  - If a tx_valid&tx_ready capture and LOAD occur in the same cycle, LOAD sees the buffer as empty: zeros are loaded, underrun is set, and the new word stays for the next frame.
- underrun clears only on reset.
- rx_valid has no backpressure. Unread words are overwritten.

## Timing
- Reset values: MISO 0, rx_data 0, rx_valid 0, tx_ready 1, busy 0, underrun 0, state IDLE, mode register 0.
- Pin CS fall → busy high: 3 clk cycles. LOAD occurs on that same cycle, and MISO is valid 1 cycle later.
- Pin sample edge of the last bit → rx_valid high: 3 clk cycles. rx_valid is exactly 1 cycle wide.
- Pin shift edge → MISO change: 3 clk cycles.
- Constraints on the master:
  - SPI_CLK half-period ≥ 4 clk.
  - CS fall to first SPI_CLK edge ≥ 5 clk.
- tx_ready drops the cycle after a handshake. It rises the cycle after LOAD consumes the word.

## Configuration
- SPI_SLAVE_MISO_TRISTATE_EN:
  - Defined: MISO is 1'bz whenever busy is low, including during reset.
  - Undefined: MISO is driven 0 while busy is low.
- All other behaviour is identical in both builds.

## Test plan
- Mode 0, Data_Width=8: preload tx_data=8'hA5, master sends 8'h3C → MISO bit sequence 1,0,1,0,0,1,0,1; rx_data=8'h3C; one rx_valid pulse; underrun 0.
- Modes 1, 2, 3 each: tx 8'h96, rx 8'h69 → both words exchanged intact; mode change applied mid-frame is ignored until the next CS fall.
- CS held low for 3 words, tx buffer refilled on each tx_ready: tx 8'h01/02/03, rx 8'hF0/0F/FF → three rx_valid pulses in order with matching data.
- No tx word loaded before CS fall → MISO sends 8'h00; underrun=1 and stays 1 until rst low.
- CS raised after 5 bits → no rx_valid; rx_data unchanged; busy drops within 3 clk. The next full frame transfers correctly.
- rst asserted mid-frame → all outputs at reset values immediately (asynchronous); tx_ready=1; MISO per SPI_SLAVE_MISO_TRISTATE_EN build.
